// File: rtl/gfifo_wr_arb.sv
// ============================================================================
// Module   : gfifo_wr_arb
// Purpose  : Round-robin, burst-limited write-port arbiter for the gray-code
//            async FIFO. Optional macro GFIFO_WR_ARB_PRIO0_EN lets requester 0
//            win every arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gfifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                        wr_clk,
  input  logic                        rst_,
  input  logic [NUM_REQ-1:0]          src_req_,
  input  logic [NUM_REQ*DATA_W-1:0]   src_data,
  output logic [NUM_REQ-1:0]          src_gnt_,
  output logic [NUM_REQ-1:0]          src_ack_,
  output logic                        fifo_wr_req_,
  output logic [DATA_W-1:0]           fifo_wr_data,
  input  logic                        fifo_full,
  output logic                        arb_busy
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam int c_SUM_W = c_IDX_W + 1;
  localparam int c_CNT_W = $clog2(BURST_MAX + 1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_BURST = 1'b1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST_MAX - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_REQ - 1);
  localparam logic [c_SUM_W-1:0] c_NUM     = c_SUM_W'(NUM_REQ);

  logic [0:0]         r_state;
  logic [c_IDX_W-1:0] r_owner;
  logic [c_IDX_W-1:0] r_rr_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [NUM_REQ-1:0] r_gnt_n;

  logic               w_found;
  logic [c_IDX_W-1:0] w_sel;
  logic [c_SUM_W-1:0] w_idx;
  logic [DATA_W-1:0]  w_owner_data;
  logic               w_owner_req_n;
  logic               w_busy;
  logic               w_xfer;
  logic               w_end;
  logic [c_IDX_W-1:0] w_rr_next;

  // First low request at or after r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
`ifdef GFIFO_WR_ARB_PRIO0_EN
    if (!src_req_[0]) begin
      w_found = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + c_SUM_W'(i);
      if (w_idx >= c_NUM) begin
        w_idx = w_idx - c_NUM;
      end
      if (!w_found && !src_req_[w_idx[c_IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[c_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (c_IDX_W'(i) == r_owner) begin
        w_owner_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_owner_req_n = src_req_[r_owner];
  assign w_busy        = (r_state == c_BURST);
  assign w_xfer        = w_busy && !w_owner_req_n && !fifo_full;
  // Burst closes on its last word or as soon as the owner withdraws.
  assign w_end         = w_busy && (w_owner_req_n || (w_xfer && (r_cnt == c_CNT_LAST)));
  assign w_rr_next     = (r_owner == c_IDX_LAST) ? '0 : r_owner + c_IDX_W'(1);

  always_comb begin
    src_ack_ = '1;
    if (w_xfer) begin
      src_ack_[r_owner] = 1'b0;
    end
  end

  assign fifo_wr_req_ = !w_xfer;
  assign fifo_wr_data = w_xfer ? w_owner_data : '0;
  assign src_gnt_     = r_gnt_n;
  assign arb_busy     = w_busy;

  always_ff @(posedge wr_clk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= c_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_gnt_n  <= '1;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_state <= c_BURST;
            r_owner <= w_sel;
            r_cnt   <= '0;
            r_gnt_n <= ~(NUM_REQ'(1) << w_sel);
          end
        end
        c_BURST: begin
          if (w_end) begin
            r_state  <= c_IDLE;
            r_rr_ptr <= w_rr_next;
            r_cnt    <= '0;
            r_gnt_n  <= '1;
          end else if (w_xfer) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gfifo_wr_arb.sv
// ============================================================================
// Module   : tb_gfifo_wr_arb
// Purpose  : Directed and randomized self-checking bench for gfifo_wr_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gfifo_wr_arb;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int BM = 4;

  logic           wr_clk = 1'b0;
  logic           rst_;
  logic [N-1:0]   src_req_;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_gnt_;
  logic [N-1:0]   src_ack_;
  logic           fifo_wr_req_;
  logic [W-1:0]   fifo_wr_data;
  logic           fifo_full;
  logic           arb_busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Producer word queues and enables
  int q[N][$];
  bit en[N];

  // Reference model: current owner (-1 = none), words left in burst, next rr start
  int m_owner;
  int m_budget;
  int m_next;

  int wl_cyc[$];
  int wl_dat[$];
  int gl[$];
  logic [N-1:0] prev_gnt;
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int c0;

  gfifo_wr_arb #(.NUM_REQ(N), .DATA_W(W), .BURST_MAX(BM)) dut (
    .wr_clk       (wr_clk),
    .rst_         (rst_),
    .src_req_     (src_req_),
    .src_data     (src_data),
    .src_gnt_     (src_gnt_),
    .src_ack_     (src_ack_),
    .fifo_wr_req_ (fifo_wr_req_),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .arb_busy     (arb_busy)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    #2;
    rst_ = 1'b0;
    #1;
    chk("rst_wr_req", fifo_wr_req_, 1);
    chk("rst_gnt", src_gnt_, {N{1'b1}});
    chk("rst_ack", src_ack_, {N{1'b1}});
    chk("rst_busy", arb_busy, 0);
    chk("rst_data", fifo_wr_data, 0);
    src_req_  = '1;
    fifo_full = 1'b0;
    m_owner   = -1;
    m_budget  = 0;
    m_next    = 0;
    prev_gnt  = '1;
    @(negedge wr_clk);
    rst_ = 1'b1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0;
      q[i].delete();
    end
  endtask

  task automatic cycle(input bit full);
    logic [N-1:0]   rq;
    logic [N*W-1:0] dt;
    logic [N-1:0]   e_gnt;
    logic [N-1:0]   e_ack;
    logic [W-1:0]   e_dat;
    bit             e_wr;
    int             pick;
    int             o;
    @(negedge wr_clk);
    for (int i = 0; i < N; i++) begin
      rq[i] = !(en[i] && (q[i].size() > 0));
      dt[i*W +: W] = rq[i] ? W'($urandom) : W'(q[i][0]);
    end
    src_req_  = rq;
    src_data  = dt;
    fifo_full = full;
    #1;
    e_gnt = '1;
    e_ack = '1;
    e_dat = '0;
    e_wr  = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b0;
      if (!rq[m_owner] && !full) e_wr = 1'b1;
    end
    if (e_wr) begin
      e_ack[m_owner] = 1'b0;
      e_dat = dt[m_owner*W +: W];
    end
    chk("gnt", src_gnt_, e_gnt);
    chk("busy", arb_busy, (m_owner >= 0) ? 1 : 0);
    chk("wr_req", fifo_wr_req_, e_wr ? 0 : 1);
    chk("ack", src_ack_, e_ack);
    chk("wr_data", fifo_wr_data, e_dat);
    if (prev_gnt == '1 && src_gnt_ != '1) begin
      for (int i = 0; i < N; i++) if (!src_gnt_[i]) gl.push_back(i);
    end
    prev_gnt = src_gnt_;
    if (!fifo_wr_req_) begin
      wl_cyc.push_back(cyc);
      wl_dat.push_back(int'(fifo_wr_data));
    end
    o = m_owner;
    if (o < 0) begin
      pick = -1;
`ifdef GFIFO_WR_ARB_PRIO0_EN
      if (!rq[0]) pick = 0;
`endif
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && !rq[(m_next + k) % N]) pick = (m_next + k) % N;
      end
      if (pick >= 0) begin
        m_owner  = pick;
        m_budget = BM;
      end
    end else if (rq[o]) begin
      m_next  = (o + 1) % N;
      m_owner = -1;
    end else if (!full) begin
      void'(q[o].pop_front());
      m_budget = m_budget - 1;
      if (m_budget == 0) begin
        m_next  = (o + 1) % N;
        m_owner = -1;
      end
    end
    @(posedge wr_clk);
    cyc = cyc + 1;
  endtask

  initial begin
    rst_      = 1'b1;
    src_req_  = '1;
    src_data  = '0;
    fifo_full = 1'b0;
    clear_all();
    do_reset();

    // Single producer, five words: 4-word burst, one idle cycle, then the fifth
    en[2] = 1'b1;
    q[2]  = '{1, 2, 3, 4, 5};
    wl_cyc.delete(); wl_dat.delete();
    c0 = cyc;
    for (int k = 0; k < 20 && q[2].size() > 0; k++) cycle(1'b0);
    chk("t1_drained", q[2].size(), 0);
    cycle(1'b0);
    cycle(1'b0);
    chk("t1_nwrites", wl_dat.size(), 5);
    for (int k = 0; k < 5; k++) chk("t1_data", (k < wl_dat.size()) ? wl_dat[k] : -1, k + 1);
    chk("t1_first_cyc", (wl_cyc.size() > 0) ? wl_cyc[0] : -1, c0 + 1);
    chk("t1_fourth_cyc", (wl_cyc.size() > 3) ? wl_cyc[3] : -1, c0 + 4);
    chk("t1_fifth_cyc", (wl_cyc.size() > 4) ? wl_cyc[4] : -1, c0 + 6);
    clear_all();

    // All four producers from reset: grant order 0,1,2,3,0
    do_reset();
    gl.delete(); wl_cyc.delete(); wl_dat.delete();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1;
      for (int k = 0; k < 8; k++) q[i].push_back(int'($urandom_range(0, 15)));
    end
    for (int k = 0; k < 25; k++) cycle(1'b0);
    chk("t2_ngrants", gl.size(), 5);
    for (int k = 0; k < 5; k++) chk("t2_order", (k < gl.size()) ? gl[k] : -1, exp_order[k]);
    chk("t2_nwrites", wl_dat.size(), 20);
    clear_all();
    cycle(1'b0);
    cycle(1'b0);

    // Full stall for 3 cycles after 2 words
    en[1] = 1'b1;
    for (int k = 0; k < 6; k++) q[1].push_back(k + 9);
    wl_dat.delete(); wl_cyc.delete();
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    chk("t3_nwrites", wl_dat.size(), 4);
    chk("t3_left", q[1].size(), 2);
    cycle(1'b0);
    clear_all();
    cycle(1'b0);
    cycle(1'b0);

    // Owner withdraws after 1 word while requester 3 waits
    en[2] = 1'b1; q[2] = '{7};
    en[3] = 1'b1; q[3] = '{8, 9};
    gl.delete(); wl_dat.delete(); wl_cyc.delete();
    for (int k = 0; k < 6; k++) cycle(1'b0);
    chk("t4_ngrants", gl.size(), 2);
    chk("t4_first", (gl.size() > 0) ? gl[0] : -1, 2);
    chk("t4_second", (gl.size() > 1) ? gl[1] : -1, 3);
    chk("t4_gap", (wl_cyc.size() > 1) ? (wl_cyc[1] - wl_cyc[0]) : -1, 3);
    clear_all();
    cycle(1'b0);
    cycle(1'b0);

    // Reset mid-burst, then all request: requester 0 wins
    en[1] = 1'b1;
    for (int k = 0; k < 4; k++) q[1].push_back(k + 3);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    do_reset();
    clear_all();
    gl.delete();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1;
      for (int k = 0; k < 4; k++) q[i].push_back(int'($urandom_range(0, 15)));
    end
    cycle(1'b0);
    cycle(1'b0);
    chk("t5_first_after_rst", (gl.size() > 0) ? gl[0] : -1, 0);
    clear_all();
    cycle(1'b0);

    // Randomized traffic, stalls, withdrawals and occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          for (int k = 0; k < int'($urandom_range(1, 6)); k++) q[i].push_back(int'($urandom_range(0, 15)));
        end
        en[i] = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gfifo_wr_arb.md
# gfifo_wr_arb

Write-side arbiter that shares the single write port of the gray-code async FIFO among `NUM_REQ` producers in the write clock domain. Each cycle it selects at most one producer, forwards that producer's word onto the FIFO write port, and returns a per-producer acknowledge. Grants are round-robin and burst-limited, and every transfer is gated by FIFO `full`. It sits between the producer blocks and the FIFO write side (`wr_clk`, `rst_`, `wr_data`, `wr_req_`, `full`).

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers; legal range 2..8.
- `DATA_W`, 4: word width; must equal the FIFO data width.
- `BURST_MAX`, 4: maximum words per grant; legal range 1..15.

Ports (clock and reset first):
- `wr_clk`, input, 1: FIFO write clock. This is the only clock.
- `rst_`, input, 1: asynchronous, active-low reset.
- `src_req_`, input, `NUM_REQ`: per-producer request, active-low. Low means the producer has a valid word on its `src_data` slice.
- `src_data`, input, `NUM_REQ*DATA_W`: producer words. Producer i drives bits `[i*DATA_W +: DATA_W]`.
- `src_gnt_`, output, `NUM_REQ`: registered grant, active-low, at most one bit low.
- `src_ack_`, output, `NUM_REQ`: combinational, active-low. Low means the word was written to the FIFO this cycle.
- `fifo_wr_req_`, output, 1: FIFO write request, active-low.
- `fifo_wr_data`, output, `DATA_W`: FIFO write data.
- `fifo_full`, input, 1: FIFO full flag.
- `arb_busy`, output, 1: registered. High whenever state is BURST.

## Operation
Registered state:
- `state` (IDLE or BURST)
- `owner` (index)
- `rr_ptr` (index)
- `cnt` (width `$clog2(BURST_MAX+1)`)

IDLE:
- If any `src_req_` bit is low, register `owner` as the first requester with its bit low, scanning from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- On that selection: `cnt` <= 0, state <= BURST, `src_gnt_[owner]` <= 0.
- Otherwise remain in IDLE.

BURST, transfer condition: `xfer = !src_req_[owner] && !fifo_full`.
- When `xfer` is true:
  - `fifo_wr_req_` = 0.
  - `fifo_wr_data` = the owner's slice of `src_data`.
  - `src_ack_[owner]` = 0.
  - `cnt` increments.
- When `xfer` is false: `fifo_wr_req_` = 1, `fifo_wr_data` = 0, all `src_ack_` bits = 1.

BURST ends, and the next state is IDLE, in either of these cycles:
- `xfer` is true and `cnt == BURST_MAX-1` (the last word of the burst is written).
- `src_req_[owner]` is high (the owner withdrew; no transfer occurs).

On burst end:
- `rr_ptr` <= (`owner`+1) mod `NUM_REQ`.
- `src_gnt_` <= all ones.
- `cnt` <= 0.

Full stall:
- While `fifo_full` is high and the owner is still requesting: grant is held, `cnt` is frozen, no write is issued.
- There is no timeout. The grant is kept until the FIFO drains.

The `src_ack_` bits of non-owners are always 1.

## Timing
- Reset values (asynchronous, while `rst_` is low):
  - state = IDLE, `rr_ptr` = 0, `owner` = 0, `cnt` = 0.
  - `src_gnt_` = all ones, `src_ack_` = all ones.
  - `fifo_wr_req_` = 1, `fifo_wr_data` = 0, `arb_busy` = 0.
- Arbitration latency: a request low at edge N produces a grant from edge N+1. The first write can occur in the cycle after edge N+1.
- A write occurs in the same cycle as its `src_ack_`. The producer must advance its data and request at the next edge.
- Throughput: one word per cycle within a burst. Every burst end costs one IDLE cycle before the next grant.
- `fifo_full` is used combinationally. A write is never issued in a cycle where `fifo_full` = 1, so a write in the cycle that fills the FIFO is legal.
- Reset mid-burst drops the grant immediately. No write is issued while `rst_` is low.
- Wrap-around: `rr_ptr` moves from `NUM_REQ-1` back to 0.

## Configuration
Macro: `GFIFO_WR_ARB_PRIO0_EN`.
- Defined: in IDLE, requester 0 wins whenever its `src_req_` bit is low, regardless of `rr_ptr`. Burst limit and `rr_ptr` update are unchanged.
- Not defined: pure round-robin as described above.

## Test plan
- Single producer: `src_req_[2]`=0 continuously, data 0x1,0x2,0x3,0x4,0x5, `BURST_MAX`=4 → 1-cycle grant latency; writes 0x1–0x4 on consecutive cycles; one IDLE cycle; then 0x5.
- All four producers requesting from reset → grant order 0,1,2,3,0. Each grant writes 4 words. Each burst is followed by one cycle with `fifo_wr_req_`=1.
- `fifo_full`=1 for 3 cycles mid-burst after 2 words → no writes and no acks for those 3 cycles; `cnt` holds at 2; remaining 2 words are written after full clears; the grant is held throughout.
- Owner raises `src_req_` after 1 word while requester 3 waits → burst ends; `rr_ptr` = owner+1; requester 3 is granted after one IDLE cycle.
- `rst_` asserted mid-burst → `fifo_wr_req_`, `src_gnt_`, `src_ack_` go high and `arb_busy` goes to 0 asynchronously; after release the next grant goes to requester 0.
- With `GFIFO_WR_ARB_PRIO0_EN` defined and requesters 0 and 1 both requesting continuously → requester 0 wins every IDLE cycle; requester 1 is never granted.
